// File: rtl/ring_arbiter_pkg.sv
// Shared types and helpers for the round-robin ring arbiter.
package ring_arbiter_pkg;

  // Default configuration; the top level derives its own widths from its parameters.
  localparam int N_DFLT       = 4;
  localparam int QUANTUM_DFLT = 8;
  localparam int IDXW         = $clog2(N_DFLT);
  localparam int CNTW         = $clog2(QUANTUM_DFLT);

  // Widest ring the rotate helper supports.
  localparam int MAXN = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Rotate the low n bits of v left by one, wrapping bit n-1 into bit 0.
  function automatic logic [MAXN-1:0] onehot_rotl1(input logic [MAXN-1:0] v, input int n);
    logic [MAXN-1:0] r;
    int              ip;
    r = '0;
    for (int i = 0; i < MAXN; i++) begin
      ip = i + 1;
      if (i < n) begin
        if (i == n - 1) r[0] = v[i[4:0]];
        else            r[ip[4:0]] = v[i[4:0]];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ring_arbiter_rr_pick.sv
// Combinational circular priority search: first set request at or above the token.
module rr_pick
  import ring_arbiter_pkg::*;
#(
  parameter int N  = N_DFLT,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [N-1:0]  token_i,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);

  // Scan offsets from farthest to nearest so the closest requester overwrites the rest.
  always_comb begin
    int p;
    p       = 0;
    valid_o = 1'b0;
    idx_o   = '0;
    for (int j = 0; j < N; j++) begin
      if (token_i[j[IW-1:0]]) begin
        for (int k = N - 1; k >= 0; k--) begin
          p = (j + k) % N;
          if (req_i[p[IW-1:0]]) begin
            valid_o = 1'b1;
            idx_o   = p[IW-1:0];
          end
        end
      end
    end
  end

endmodule

// File: rtl/ring_arbiter.sv
// Round-robin arbiter with a rotating one-hot priority token and a hold quantum.
module ring_arbiter
  import ring_arbiter_pkg::*;
#(
  parameter int N       = N_DFLT,
  parameter int QUANTUM = QUANTUM_DFLT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         done,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 busy,
  output logic                 timeout,
  output logic [N-1:0]         token
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(QUANTUM);

  state_e          state_q;
  logic [N-1:0]    gnt_q;
  logic [N-1:0]    token_q;
  logic [IW-1:0]   gnt_idx_q;
  logic            busy_q;
  logic            timeout_q;
  logic [CW-1:0]   hold_cnt_q;

  logic            pick_valid;
  logic [IW-1:0]   pick_idx;
  logic [N-1:0]    gnt_d;
  logic [N-1:0]    token_d;
  logic [MAXN-1:0] gnt_ext;
  logic [MAXN-1:0] rot_ext;
  logic            done_hit;
  logic            req_hit;
  logic            expire;

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req_i   (req),
    .token_i (token_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  // Candidate grant vector, next token and release conditions for the current grantee.
  always_comb begin
    gnt_d           = '0;
    gnt_d[pick_idx] = 1'b1;
    gnt_ext         = '0;
    gnt_ext[N-1:0]  = gnt_q;
    rot_ext         = onehot_rotl1(gnt_ext, N);
    token_d         = rot_ext[N-1:0];
    done_hit        = done[gnt_idx_q];
    req_hit         = req[gnt_idx_q];
    expire          = (hold_cnt_q == CW'(QUANTUM - 1));
  end

  // Arbitration FSM: idle search, grant hold, release with token advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      gnt_idx_q  <= '0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      token_q    <= {{(N-1){1'b0}}, 1'b1};
      hold_cnt_q <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            state_q    <= GRANT;
            gnt_q      <= gnt_d;
            gnt_idx_q  <= pick_idx;
            busy_q     <= 1'b1;
            hold_cnt_q <= '0;
          end
        end
        GRANT: begin
          if (done_hit || !req_hit || expire) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            gnt_idx_q  <= '0;
            busy_q     <= 1'b0;
            token_q    <= token_d;
            hold_cnt_q <= '0;
            // Only a pure quantum expiry counts as a timeout; done or withdrawal take precedence.
            timeout_q  <= !done_hit && req_hit;
          end else begin
            hold_cnt_q <= hold_cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign gnt_idx = gnt_idx_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;
  assign token   = token_q;

endmodule

// File: doc/ring_arbiter.md
# ring_arbiter

Round-robin arbiter that shares one ring-counter datapath among N requesters. It holds a one-hot priority token that rotates like a ring counter, and grants the resource to one requester at a time. Each grant ends on a done handshake, on request withdrawal, or on a quantum timeout. It sits between the requesting masters and the shared ring-counter datapath, and drives the datapath's ownership select.

## Interface
- N, 4, number of requesters (≥2)
- QUANTUM, 8, maximum consecutive cycles a grant is held (≥2)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req  input  N  per-requester request, level; must stay high until done or withdrawal
- done  input  N  per-requester completion strobe; only the current grantee's bit is used
- gnt  output  N  one-hot grant, registered
- gnt_idx  output  $clog2(N)  binary index of the current grantee; 0 when idle
- busy  output  1  high while any gnt bit is set
- timeout  output  1  one-cycle pulse when a grant is revoked by quantum expiry
- token  output  N  one-hot priority pointer, registered

## Operation
- States:
  - IDLE: gnt=0.
  - GRANT: exactly one gnt bit set.
- Reset (async, immediate): state=IDLE, gnt=0, gnt_idx=0, busy=0, timeout=0, token=1 (bit 0), hold_cnt=0.
- Arbitration (IDLE only):
  - Search req circularly, starting at the token bit position and moving upward, wrapping from N-1 to 0.
  - The first set bit wins.
  - If req==0, stay in IDLE.
- Grant issue:
  - On the edge after IDLE sees a nonzero req: state=GRANT, gnt=onehot(winner), gnt_idx=winner, hold_cnt=0.
- GRANT: hold_cnt increments each cycle. Release conditions, in priority order:
  1. done[gnt_idx]=1 → normal release, timeout stays 0.
  2. req[gnt_idx]=0 → withdrawal release, timeout stays 0.
  3. hold_cnt==QUANTUM-1 → forced release, timeout=1 for one cycle.
- Release edge:
  - state=IDLE, gnt=0, gnt_idx=0.
  - token becomes onehot((grantee+1) mod N).
- Token changes only on release.
- done bits of non-grantees are ignored in all states.
- done seen in IDLE is ignored.
- No requester is starved: each release moves priority past the grantee.

## Timing
- Request to grant latency: req sampled high in cycle c (IDLE) → gnt high in cycle c+1.
- Release latency: release condition in cycle c → gnt low in cycle c+1.
- Mandatory gap: at least one cycle of gnt=0 between consecutive grants, even for the same requester.
- Back-to-back grants occur every (hold + 1) cycles.
- Maximum grant length: exactly QUANTUM cycles of gnt high.
- timeout is high in the first IDLE cycle after a forced release, coincident with gnt=0.
- Simultaneous events:
  - done together with quantum expiry → normal release, no timeout.
  - req drop together with quantum expiry → withdrawal release, no timeout.
- Reset during GRANT: gnt drops asynchronously. No timeout pulse is produced, and the token returns to bit 0.
- busy equals |gnt. It is registered and has the same timing as gnt.

## Structure
- Shared package ring_arbiter_pkg contains:
  - state enum {IDLE, GRANT}
  - function onehot_rotl1(token) for the ring rotate
  - localparam IDXW = $clog2(N) and CNTW = $clog2(QUANTUM)
- Sub-module rr_pick is purely combinational. Inputs are req[N] and token[N]. Outputs are valid and idx[IDXW]: the first set req at or above the token position, wrapping.
- Top level contains the FSM, hold_cnt, token register and output registers.

## Test plan
- Reset then single request: rst high 2 cycles, req=0100 from cycle 3 → gnt=0100 and gnt_idx=2 from cycle 4. done[2] at cycle 6 → gnt=0 at cycle 7, token=1000.
- Round-robin fairness: req=1111 held, each grantee pulses done one cycle after grant → grant order 0,1,2,3,0, with a 1-cycle gnt=0 gap between grants. token after each release = 0010, 0100, 1000, 0001.
- Quantum timeout: QUANTUM=8, req=0010 held, no done → gnt=0010 for exactly 8 cycles, then gnt=0 with timeout=1 for 1 cycle, token=0100. Regrant to requester 1 the next cycle.
- Simultaneous events: done[1] asserted on the 8th grant cycle → release with timeout=0. A separate run has req[1] drop on the 8th cycle → also timeout=0.
- Foreign done and withdrawal: grantee 0 active, done=1110 pulsed → no release. req[0] then dropped → gnt=0 next cycle, token=0010.
- Reset mid-grant: rst asserted asynchronously mid-cycle during gnt=1000 → gnt, busy and timeout go to 0 immediately, token=0001. After rst deasserts with req=1001, grant goes to requester 0.
